jk_down_up_counter: RTL and testbench
=====================================

// Module: jk_down_up_counter
// PURPOSE
// - WIDTH-bit synchronous up/down counter built from per-bit JK flip-flops.
// - Complements the existing up-only JK counter: adds the down direction, parallel load and terminal-count/wrap reporting.
// - Used as a loadable timebase/decrementing tick counter in small control datapaths.
// PARAMETERS
// - WIDTH     3  counter width in bits (>=2)
// - SATURATE  0  0: wrap at terminal count; 1: hold at terminal count
// PORTS
// - clk       in   1      clock, all state updates on posedge
// - rst       in   1      reset, synchronous, active-high
// - en        in   1      count enable
// - up_dn     in   1      direction: 1 = up, 0 = down
// - load      in   1      synchronous parallel load request
// - load_val  in   WIDTH  value loaded when load=1
// - q         out  WIDTH  counter state, registered
// - tc        out  1      terminal count, combinational: en & (up_dn ? q=={WIDTH{1}} : q==0)
// - wrap      out  1      registered 1-cycle pulse: previous edge wrapped (max->0 or 0->max)
// BEHAVIOUR
// - Reset: rst=1 at posedge -> q=0, wrap=0; tc follows q/en combinationally; rst overrides all inputs.
// - Priority per edge: rst > load > en > hold.
// - Every bit updates only through JK excitation: q_i' = (J_i & ~q_i) | (~K_i & q_i).
// - Count (en=1, load=0): J_0=K_0=1.
//   - up:   J_i=K_i = &q[i-1:0]
//   - down: J_i=K_i = &~q[i-1:0]
// - Load (load=1): J_i=load_val[i], K_i=~load_val[i], giving q'=load_val in one cycle regardless of en/up_dn; wrap'=0.
// - Hold (en=0, load=0): all J=K=0; q unchanged; wrap'=0.
// - Latency: q reflects a count/load one cycle after the sampling edge; no pipeline.
// - Wrap boundary, SATURATE=0: up from all-ones -> 0, down from 0 -> all-ones; wrap'=1 on that edge only.
// - Saturate boundary, SATURATE=1: when tc=1, all J=K=0; q holds; wrap stays 0.
// - Direction change is legal on any cycle: takes effect at the next edge; no dead cycle.
// - Simultaneous load & tc: load wins; no wrap pulse.
// - Reset mid-count: q=0 at that edge; counting resumes from 0 on the first edge with rst=0 and en=1.
// - No X propagation allowed: all regs have reset values; J/K logic is fully combinational on q and inputs.
// STRUCTURE
// - Shared package holds:
//   - JK excitation encodings: JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TOG=2'b11
//   - Direction constants: DIR_UP=1'b1, DIR_DN=1'b0
// - Sub-module jk_ff (clk, rst, j, k, q): one bit, synchronous reset to 0; instantiated WIDTH times via generate.
// - Top level holds:
//   - Excitation network: prefix-AND chains for up and down, muxed by up_dn, overridden by load/saturate
//   - tc compare and wrap register
// TESTING
// - Reset: hold rst 2 cycles with en=1, up_dn=1 -> q=0, wrap=0 throughout; first en edge after release -> q=1.
// - Up wrap (WIDTH=3, SATURATE=0): en=1, up_dn=1 for 9 edges from 0 -> q 1..7,0,1; tc=1 while q=7; wrap=1 only in the cycle q=0.
// - Down wrap: load 3, then up_dn=0, en=1 for 5 edges -> q 2,1,0,7,6; wrap=1 only in the cycle q=7.
// - Load priority: q=5, counting up; load=1, load_val=2, en=1 -> q=2 next edge, wrap=0; load with en=0 also gives 2.
// - Saturate (SATURATE=1): count up to 7 and hold en=1 for 3 more edges -> q stays 7, wrap=0; flip up_dn=0 -> q=6.
// - Mid-run: at q=4 counting down, assert rst with load=1 -> q=0; toggle up_dn every cycle after release -> q 1,0,1,0 pattern.

Source files
------------

// File: rtl/jk_down_up_counter_pkg.sv
// Shared definitions for the JK-based up/down counter: flip-flop excitation
// encodings and direction constants.
package jk_down_up_counter_pkg;

    // {J,K} pair as presented to a single JK flip-flop
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/jk_down_up_counter_jk_ff.sv
// Single JK flip-flop with synchronous active-high reset to 0.
module jk_ff
    import jk_down_up_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            unique case (jk_e'({j, k}))
                JK_HOLD: q <= q;
                JK_RST:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                JK_TOG:  q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_down_up_counter.sv
// Loadable up/down counter built from per-bit JK flip-flops, with a
// combinational terminal-count flag and a registered wrap pulse.
module jk_down_up_counter
    import jk_down_up_counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic SAT = (SATURATE != 0);

    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             cnt_go;
    logic             wrap_nxt;

    // Bit i toggles once every lower bit is 1 (up) or 0 (down)
    assign up_t[0] = 1'b1;
    assign dn_t[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
        assign up_t[i] = up_t[i-1] & q[i-1];
        assign dn_t[i] = dn_t[i-1] & ~q[i-1];
    end

    assign tog = (up_dn == DIR_UP) ? up_t : dn_t;
    assign tc  = en & ((up_dn == DIR_UP) ? (&q) : ~(|q));

    // Saturating variant freezes at terminal count instead of rolling over
    assign cnt_go   = en & ~(SAT & tc);
    assign wrap_nxt = ~load & tc & ~SAT;

    always_comb begin
        j = '0;
        k = '0;
        if (load) begin
            j = load_val;
            k = ~load_val;
        end else if (cnt_go) begin
            j = tog;
            k = tog;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_ff u_ff (
            .clk (clk),
            .rst (rst),
            .j   (j[i]),
            .k   (k[i]),
            .q   (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_jk_down_up_counter.sv
// Self-checking bench: a wrapping and a saturating counter share stimulus and
// are compared against an arithmetic reference model.
module tb_jk_down_up_counter;

    localparam int W    = 3;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up_dn = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q0, q1;
    logic         tc0, tc1, wrap0, wrap1;

    int total = 0;
    int bad   = 0;

    // reference state for wrapping (m0) and saturating (m1) counters
    int m0 = 0, m1 = 0;
    bit mw0 = 0, mw1 = 0;

    always #5 clk = ~clk;

    jk_down_up_counter #(.WIDTH(W), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q0), .tc(tc0), .wrap(wrap0)
    );

    jk_down_up_counter #(.WIDTH(W), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q1), .tc(tc1), .wrap(wrap1)
    );

    task automatic model_step(input bit sat, inout int v, output bit w);
        w = 0;
        if (rst) v = 0;
        else if (load) v = int'(load_val);
        else if (en) begin
            if (up_dn) begin
                if (v == MAXV) begin
                    if (!sat) begin v = 0; w = 1; end
                end else v = v + 1;
            end else begin
                if (v == 0) begin
                    if (!sat) begin v = MAXV; w = 1; end
                end else v = v - 1;
            end
        end
    endtask

    task automatic set_in(input bit r, input bit e, input bit u, input bit l, input int lv);
        rst = r; en = e; up_dn = u; load = l; load_val = W'(lv);
    endtask

    task automatic tick();
        int n0, n1;
        bit w0, w1;
        n0 = m0; n1 = m1;
        model_step(0, n0, w0);
        model_step(1, n1, w1);
        @(posedge clk);
        #1;
        m0 = n0; m1 = n1; mw0 = w0; mw1 = w1;
    endtask

    task automatic drive(input bit r, input bit e, input bit u, input bit l, input int lv);
        set_in(r, e, u, l, lv);
        tick();
    endtask

    task automatic test_reset();
        for (int n = 0; n < 2; n++) begin
            drive(1, 1, 1, 0, 0);
            total++;
            if (q0 !== 3'd0 || q1 !== 3'd0) begin
                bad++; $display("FAIL reset_q cycle %0d got %0d/%0d want 0", n, q0, q1);
            end
            total++;
            if (wrap0 !== 1'b0 || wrap1 !== 1'b0) begin
                bad++; $display("FAIL reset_wrap cycle %0d got %b/%b want 0", n, wrap0, wrap1);
            end
        end
        drive(0, 1, 1, 0, 0);
        total++;
        if (q0 !== 3'd1 || q1 !== 3'd1) begin
            bad++; $display("FAIL reset_release got %0d/%0d want 1", q0, q1);
        end
    endtask

    task automatic test_up_wrap();
        drive(1, 0, 1, 0, 0);
        for (int n = 1; n <= 9; n++) begin
            drive(0, 1, 1, 0, 0);
            total++;
            if (q0 !== W'(n % 8)) begin
                bad++; $display("FAIL up_wrap_q step %0d got %0d want %0d", n, q0, n % 8);
            end
            total++;
            if (wrap0 !== (n == 8)) begin
                bad++; $display("FAIL up_wrap_pulse step %0d got %b want %b", n, wrap0, n == 8);
            end
            total++;
            if (tc0 !== (n == 7)) begin
                bad++; $display("FAIL up_wrap_tc step %0d got %b want %b", n, tc0, n == 7);
            end
        end
    endtask

    task automatic test_down_wrap();
        int exp_q[5] = '{2, 1, 0, 7, 6};
        drive(0, 0, 1, 1, 3);
        total++;
        if (q0 !== 3'd3) begin
            bad++; $display("FAIL down_load got %0d want 3", q0);
        end
        for (int n = 0; n < 5; n++) begin
            drive(0, 1, 0, 0, 0);
            total++;
            if (q0 !== W'(exp_q[n])) begin
                bad++; $display("FAIL down_wrap_q step %0d got %0d want %0d", n, q0, exp_q[n]);
            end
            total++;
            if (wrap0 !== (exp_q[n] == 7)) begin
                bad++; $display("FAIL down_wrap_pulse step %0d got %b want %b", n, wrap0, exp_q[n] == 7);
            end
        end
    endtask

    task automatic test_load_priority();
        drive(1, 0, 1, 0, 0);
        for (int n = 0; n < 5; n++) drive(0, 1, 1, 0, 0);
        total++;
        if (q0 !== 3'd5) begin
            bad++; $display("FAIL load_pre got %0d want 5", q0);
        end
        drive(0, 1, 1, 1, 2);
        total++;
        if (q0 !== 3'd2 || wrap0 !== 1'b0) begin
            bad++; $display("FAIL load_en got q=%0d wrap=%b want q=2 wrap=0", q0, wrap0);
        end
        drive(0, 1, 1, 0, 0);
        drive(0, 0, 0, 1, 2);
        total++;
        if (q0 !== 3'd2) begin
            bad++; $display("FAIL load_noen got %0d want 2", q0);
        end
        // load while sitting at terminal count: load wins, no wrap
        drive(0, 0, 1, 1, 7);
        set_in(0, 1, 1, 1, 4);
        #1;
        total++;
        if (tc0 !== 1'b1) begin
            bad++; $display("FAIL load_tc_flag got %b want 1", tc0);
        end
        tick();
        total++;
        if (q0 !== 3'd4 || wrap0 !== 1'b0) begin
            bad++; $display("FAIL load_at_tc got q=%0d wrap=%b want q=4 wrap=0", q0, wrap0);
        end
    endtask

    task automatic test_saturate();
        drive(1, 0, 1, 0, 0);
        for (int n = 0; n < 7; n++) drive(0, 1, 1, 0, 0);
        total++;
        if (q1 !== 3'd7) begin
            bad++; $display("FAIL sat_reach got %0d want 7", q1);
        end
        for (int n = 0; n < 3; n++) begin
            drive(0, 1, 1, 0, 0);
            total++;
            if (q1 !== 3'd7 || wrap1 !== 1'b0) begin
                bad++; $display("FAIL sat_hold step %0d got q=%0d wrap=%b want q=7 wrap=0", n, q1, wrap1);
            end
        end
        drive(0, 1, 0, 0, 0);
        total++;
        if (q1 !== 3'd6) begin
            bad++; $display("FAIL sat_reverse got %0d want 6", q1);
        end
    endtask

    task automatic test_mid_run();
        drive(0, 0, 0, 1, 5);
        drive(0, 1, 0, 0, 0);
        total++;
        if (q0 !== 3'd4) begin
            bad++; $display("FAIL mid_pre got %0d want 4", q0);
        end
        drive(1, 1, 0, 1, 6);
        total++;
        if (q0 !== 3'd0 || q1 !== 3'd0 || wrap0 !== 1'b0) begin
            bad++; $display("FAIL mid_rst got q=%0d/%0d wrap=%b want 0", q0, q1, wrap0);
        end
        for (int n = 0; n < 4; n++) begin
            drive(0, 1, (n % 2) == 0, 0, 0);
            total++;
            if (q0 !== W'((n % 2) == 0) || wrap0 !== 1'b0) begin
                bad++; $display("FAIL mid_toggle step %0d got q=%0d wrap=%b want q=%0d wrap=0",
                                n, q0, wrap0, (n % 2) == 0);
            end
        end
    endtask

    task automatic test_random();
        bit exp_tc0, exp_tc1;
        drive(1, 0, 1, 0, 0);
        for (int n = 0; n < 300; n++) begin
            set_in(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                   $urandom_range(0, 1), ($urandom_range(0, 7) == 0), $urandom_range(0, MAXV));
            #1;
            exp_tc0 = en && (up_dn ? (m0 == MAXV) : (m0 == 0));
            exp_tc1 = en && (up_dn ? (m1 == MAXV) : (m1 == 0));
            total++;
            if (tc0 !== exp_tc0 || tc1 !== exp_tc1) begin
                bad++; $display("FAIL rand_tc iter %0d got %b/%b want %b/%b", n, tc0, tc1, exp_tc0, exp_tc1);
            end
            tick();
            total++;
            if (q0 !== W'(m0) || wrap0 !== mw0) begin
                bad++; $display("FAIL rand_wrapctr iter %0d got q=%0d wrap=%b want q=%0d wrap=%b",
                                n, q0, wrap0, m0, mw0);
            end
            total++;
            if (q1 !== W'(m1) || wrap1 !== mw1) begin
                bad++; $display("FAIL rand_satctr iter %0d got q=%0d wrap=%b want q=%0d wrap=%b",
                                n, q1, wrap1, m1, mw1);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_saturate();
        test_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
